// File: rtl/scope_trace_buffer_pkg.sv
// Shared types and constants for the oscilloscope trace buffer.
// Pixel layout is {r[1:0], g[1:0], b[1:0], 2'b00}.
package scope_pkg;

    localparam int unsigned H_SAMPLES = 640;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned SAMPLE_W  = 8;
    localparam int unsigned COORD_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
        logic [1:0] pad;
    } pixel_t;

    localparam pixel_t TRACE_COLOUR = '{r: 2'b00, g: 2'b11, b: 2'b00, pad: 2'b00};
    localparam pixel_t GRID_COLOUR  = '{r: 2'b00, g: 2'b00, b: 2'b11, pad: 2'b00};

endpackage

// File: rtl/scope_trace_buffer_if.sv
// Sample-source and VGA-side signals of the trace buffer.
// The master modport is the driver side; slave is the buffer.
interface scope_trace_buffer_if;
    import scope_pkg::*;

    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] trig_level;
    logic                run;
    logic                frame_start;
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic                visible;
    logic [7:0]          pixels;
    logic                busy;

    modport master (
        output sample, sample_valid, trig_level, run, frame_start, x, y, visible,
        input  pixels, busy
    );

    modport slave (
        input  sample, sample_valid, trig_level, run, frame_start, x, y, visible,
        output pixels, busy
    );

endinterface

// File: rtl/scope_trace_buffer_trace_ram.sv
// Simple dual-port sample memory with a registered read port (BRAM-inferable).
module trace_ram
    import scope_pkg::*;
#(
    parameter int unsigned DEPTH = H_SAMPLES,
    parameter int unsigned AW    = ADDR_W,
    parameter int unsigned DW    = SAMPLE_W
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/scope_trace_buffer.sv
// Triggered, double-buffered sweep capture rendered as a 2-cycle-latency pixel stream.
// Define SCOPE_GRATICULE_EN to overlay a 64-pixel graticule in GRID_COLOUR.
module scope_trace_buffer #(
    parameter int unsigned H_SAMPLES    = scope_pkg::H_SAMPLES,
    parameter int unsigned Y_BASE       = 367,
    parameter logic [7:0]  TRACE_COLOUR = scope_pkg::TRACE_COLOUR,
    parameter logic [7:0]  GRID_COLOUR  = scope_pkg::GRID_COLOUR
) (
    input logic                 clk,
    input logic                 reset,
    scope_trace_buffer_if.slave bus
);
    import scope_pkg::*;

    localparam int unsigned AW = ADDR_W;
    localparam int unsigned CW = COORD_W;

    state_e              state_q;
    logic                front_sel_q;
    logic [AW-1:0]       wr_addr_q;
    logic [SAMPLE_W-1:0] prev_q;
    logic                busy_q;

    logic                trig_c;
    logic                we_c;
    logic [AW-1:0]       waddr_c;
    logic                in_range_c;
    logic [AW-1:0]       raddr_c;
    logic                grid_c;

    assign trig_c = bus.sample_valid && (prev_q < bus.trig_level)
                    && (bus.sample >= bus.trig_level);

    // Back-bank write port: trigger sample lands at 0, then sequential fill.
    always_comb begin
        we_c    = 1'b0;
        waddr_c = wr_addr_q;
        if (bus.run) begin
            case (state_q)
                ST_ARMED: begin
                    we_c    = trig_c;
                    waddr_c = '0;
                end
                ST_CAPTURE: we_c = bus.sample_valid;
                default:    we_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            front_sel_q <= 1'b0;
            wr_addr_q   <= '0;
            prev_q      <= 8'hFF;
            busy_q      <= 1'b0;
        end else begin
            if (bus.sample_valid) begin
                prev_q <= bus.sample;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.run) begin
                        state_q <= ST_ARMED;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!bus.run) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (trig_c) begin
                        wr_addr_q <= AW'(1);
                        state_q   <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!bus.run) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        wr_addr_q <= '0;
                    end else if (bus.sample_valid) begin
                        if (wr_addr_q == AW'(H_SAMPLES - 1)) begin
                            wr_addr_q <= '0;
                            state_q   <= ST_HOLD;
                        end else begin
                            wr_addr_q <= wr_addr_q + AW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Swap only at a frame boundary so a sweep is never shown torn.
                    if (bus.frame_start) begin
                        front_sel_q <= ~front_sel_q;
                        state_q     <= bus.run ? ST_ARMED : ST_IDLE;
                        busy_q      <= bus.run;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_range_c = bus.x < CW'(H_SAMPLES);
    assign raddr_c    = in_range_c ? AW'(bus.x) : '0;

`ifdef SCOPE_GRATICULE_EN
    assign grid_c = (bus.x[5:0] == 6'd0) || (bus.y[5:0] == 6'd0);
`else
    assign grid_c = 1'b0;
`endif

    logic [SAMPLE_W-1:0] rd0, rd1;

    trace_ram #(.DEPTH(H_SAMPLES), .AW(AW), .DW(SAMPLE_W)) u_bank0 (
        .clk     (clk),
        .we_i    (we_c && front_sel_q),
        .waddr_i (waddr_c),
        .wdata_i (bus.sample),
        .raddr_i (raddr_c),
        .rdata_o (rd0)
    );

    trace_ram #(.DEPTH(H_SAMPLES), .AW(AW), .DW(SAMPLE_W)) u_bank1 (
        .clk     (clk),
        .we_i    (we_c && !front_sel_q),
        .waddr_i (waddr_c),
        .wdata_i (bus.sample),
        .raddr_i (raddr_c),
        .rdata_o (rd1)
    );

    logic          vis1_q;
    logic [CW-1:0] y1_q;
    logic          sel1_q;
    logic          grid1_q;
    logic [7:0]    pixels_q;
    logic [7:0]    pixels_d;
    logic [CW-1:0] trace_y_c;

    assign trace_y_c = CW'(Y_BASE) - CW'(sel1_q ? rd1 : rd0);

    // Second stage: trace wins over graticule; off-screen is black.
    always_comb begin
        pixels_d = 8'h00;
        if (vis1_q) begin
            if (y1_q == trace_y_c) begin
                pixels_d = TRACE_COLOUR;
            end else if (grid1_q) begin
                pixels_d = GRID_COLOUR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vis1_q   <= 1'b0;
            y1_q     <= '0;
            sel1_q   <= 1'b0;
            grid1_q  <= 1'b0;
            pixels_q <= 8'h00;
        end else begin
            vis1_q   <= bus.visible && in_range_c;
            y1_q     <= bus.y;
            sel1_q   <= front_sel_q;
            grid1_q  <= grid_c;
            pixels_q <= pixels_d;
        end
    end

    assign bus.pixels = pixels_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_scope_trace_buffer.sv
// Randomized and directed bench for scope_trace_buffer against a sweep-level reference model.
module tb_scope_trace_buffer;

    localparam int unsigned NS = 640;
    localparam int unsigned YB = 367;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scope_trace_buffer_if bus ();

    scope_trace_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Reference model: two sample banks, which one is shown, and capture progress.
    logic [7:0] m_bank [2][NS];
    bit         m_known [2];
    bit         m_sel;
    bit         m_armed, m_cap, m_full;
    logic [9:0] m_cnt;
    logic [7:0] m_prev;
    logic [7:0] e0, e1;
    bit         e0v, e1v;

    function automatic void model_reset();
        m_sel = 1'b0;
        m_known[0] = 1'b0;
        m_known[1] = 1'b0;
        m_armed = 1'b0;
        m_cap = 1'b0;
        m_full = 1'b0;
        m_cnt = '0;
        m_prev = 8'hFF;
        e0 = 8'h00; e1 = 8'h00; e0v = 1'b1; e1v = 1'b1;
    endfunction

    function automatic void exp_pixel(output bit v, output logic [7:0] p);
        int xi, yi;
        xi = int'(bus.x);
        yi = int'(bus.y);
        v = 1'b1;
        p = 8'h00;
        if (bus.visible && xi < int'(NS)) begin
            if (!m_known[m_sel]) begin
                v = 1'b0;
            end else if (yi == int'(YB) - int'(m_bank[m_sel][bus.x])) begin
                p = 8'h30;
            end else begin
`ifdef SCOPE_GRATICULE_EN
                if (xi % 64 == 0 || yi % 64 == 0) p = 8'h0C;
`endif
            end
        end
    endfunction

    function automatic void model_edge();
        bit trig;
        trig = bus.sample_valid && (m_prev < bus.trig_level) && (bus.sample >= bus.trig_level);
        if (m_full) begin
            if (bus.frame_start) begin
                m_sel = ~m_sel;
                m_known[m_sel] = 1'b1;
                m_full = 1'b0;
                m_armed = bus.run;
            end
        end else if (m_armed || m_cap) begin
            if (!bus.run) begin
                m_armed = 1'b0;
                m_cap = 1'b0;
            end else if (m_armed) begin
                if (trig) begin
                    m_bank[~m_sel][0] = bus.sample;
                    m_cnt = 10'd1;
                    m_armed = 1'b0;
                    m_cap = 1'b1;
                end
            end else if (bus.sample_valid) begin
                m_bank[~m_sel][m_cnt] = bus.sample;
                if (m_cnt == 10'(NS - 1)) begin
                    m_cap = 1'b0;
                    m_full = 1'b1;
                end else begin
                    m_cnt = m_cnt + 10'd1;
                end
            end
        end else if (bus.run) begin
            m_armed = 1'b1;
        end
        if (bus.sample_valid) m_prev = bus.sample;
    endfunction

    // One clock: model the edge, then check busy and the 2-cycle-delayed pixel.
    task automatic tick();
        @(posedge clk);
        e1 = e0; e1v = e0v;
        exp_pixel(e0v, e0);
        model_edge();
        @(negedge clk);
        chk("busy", 8'(bus.busy), 8'(m_armed || m_cap || m_full));
        if (e1v) chk("pix", bus.pixels, e1);
    endtask

    task automatic put(input bit valid, input logic [7:0] s);
        bus.sample_valid = valid;
        bus.sample = s;
        tick();
    endtask

    task automatic frame_pulse();
        bus.frame_start = 1'b1;
        bus.sample_valid = 1'b0;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic probe(input string tag, input int px, input int py, input bit vis,
                         input logic [7:0] exp);
        bus.x = 10'(px);
        bus.y = 10'(py);
        bus.visible = vis;
        tick();
        tick();
        chk(tag, bus.pixels, exp);
    endtask

    initial begin
        reset = 1'b1;
        bus.sample = '0; bus.sample_valid = 1'b0; bus.trig_level = 8'd100;
        bus.run = 1'b0; bus.frame_start = 1'b0;
        bus.x = '0; bus.y = '0; bus.visible = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", 8'(bus.busy), 8'h00);
        chk("rst_pix", bus.pixels, 8'h00);
        reset = 1'b0;

        // Basic sweep: 10, 200 triggers, ramp fills the rest.
        bus.run = 1'b1;
        tick();
        put(1'b1, 8'd10);
        put(1'b0, 8'd77);
        put(1'b1, 8'd200);
        for (int i = 0; i < int'(NS); i++) begin
            if ($urandom_range(0, 3) == 0) put(1'b0, 8'($urandom));
            put(1'b1, 8'(i));
        end
        put(1'b0, 8'd0);
        chk("t1_hold", 8'(bus.busy), 8'h01);
        frame_pulse();
        probe("t1_trace", 0, 167, 1'b1, 8'h30);
        probe("t1_ramp", 1, 367, 1'b1, 8'h30);

        // No crossing: stays armed, display unchanged over three frames.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 60; i++) put(1'($urandom_range(0, 1)), 8'($urandom_range(0, 99)));
            frame_pulse();
        end
        chk("t2_armed", 8'(bus.busy), 8'h01);
        probe("t2_trace", 0, 167, 1'b1, 8'h30);

        // Run dropped after 300 captured samples.
        put(1'b1, 8'd50);
        put(1'b1, 8'd150);
        for (int i = 0; i < 299; i++) put(1'b1, 8'd60);
        bus.run = 1'b0;
        put(1'b0, 8'd0);
        chk("t3_idle", 8'(bus.busy), 8'h00);
        frame_pulse();
        probe("t3_noswap", 0, 167, 1'b1, 8'h30);

        // frame_start coincident with the final write is missed.
        bus.run = 1'b1;
        tick();
        put(1'b1, 8'd20);
        put(1'b1, 8'd150);
        for (int i = 1; i < int'(NS) - 1; i++) put(1'b1, 8'd50);
        bus.frame_start = 1'b1;
        put(1'b1, 8'd50);
        bus.frame_start = 1'b0;
        put(1'b0, 8'd0);
        chk("t4_hold", 8'(bus.busy), 8'h01);
        probe("t4_old", 0, 167, 1'b1, 8'h30);
        frame_pulse();
        probe("t4_new0", 0, 217, 1'b1, 8'h30);
        probe("t4_new1", 1, 317, 1'b1, 8'h30);

        // Blanking and off-sweep columns are black.
        probe("t5_invis", 0, 217, 1'b0, 8'h00);
        probe("t5_x700", 700, 317, 1'b1, 8'h00);
`ifdef SCOPE_GRATICULE_EN
        probe("t6_grid", 64, 10, 1'b1, 8'h0C);
`else
        probe("t6_grid", 64, 10, 1'b1, 8'h00);
`endif

        // Async reset in the middle of a capture.
        put(1'b1, 8'd20);
        put(1'b1, 8'd150);
        for (int i = 0; i < 100; i++) put(1'b1, 8'($urandom));
        #2 reset = 1'b1;
        #1;
        chk("t7_rst_busy", 8'(bus.busy), 8'h00);
        chk("t7_rst_pix", bus.pixels, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Random traffic against the model.
        bus.trig_level = 8'd128;
        for (int i = 0; i < 5000; i++) begin
            int px;
            px = int'($urandom_range(0, 799));
            bus.x = 10'(px);
            bus.y = 10'($urandom_range(0, 524));
            if (px < int'(NS) && m_known[m_sel] && $urandom_range(0, 1) == 1)
                bus.y = 10'(int'(YB) - int'(m_bank[m_sel][bus.x]));
            bus.visible = ($urandom_range(0, 3) != 0);
            bus.frame_start = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 600) == 0) bus.run = ~bus.run;
            put(1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
